// File: rtl/ring_meas_pkg.sv
// Shared definitions for the ring-oscillator frequency meter: FSM encoding,
// default parameter values and the drop-compare helper.
package ring_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_HOLD = 2'd2
  } meas_state_e;

  localparam int DEF_GATE_CYCLES = 48000;
  localparam int DEF_CNT_W       = 20;
  localparam int DEF_DROP_THRESH = 5;

  // Operands arrive zero-extended to 33 bits, so new + threshold cannot wrap.
  function automatic logic is_drop(input logic [32:0] prev_ext,
                                   input logic [32:0] new_ext,
                                   input logic [32:0] thr_ext);
    return (prev_ext > (new_ext + thr_ext));
  endfunction

endpackage

// File: rtl/ring_freq_meter_if.sv
// Result handshake bundle: the meter presents count and flags with valid,
// the consumer answers with ready.
interface ring_freq_meter_if #(
  parameter int CNT_W = 20
) ();
  logic [CNT_W-1:0] meas_count;
  logic             meas_valid;
  logic             meas_ready;
  logic             overflow;
  logic             drop_flag;

  modport master (
    output meas_count,
    output meas_valid,
    output overflow,
    output drop_flag,
    input  meas_ready
  );

  modport slave (
    input  meas_count,
    input  meas_valid,
    input  overflow,
    input  drop_flag,
    output meas_ready
  );
endinterface

// File: rtl/ring_edge_sync.sv
// Brings the asynchronous prescaled oscillator into the clk48 domain and
// produces a one-cycle pulse per rising edge.
module ring_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  // sync_q[0] = first stage, sync_q[1] = stable stage, sync_q[2] = delayed copy
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the raw input through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  // Synchroniser registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign edge_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ring_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronised rising edges over a
// fixed gate of clk48 cycles and hands the result out over valid/ready,
// with saturation and frequency-drop flags.
module ring_freq_meter
  import ring_meas_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DROP_THRESH = DEF_DROP_THRESH
) (
  input  logic                      clk48,
  input  logic                      rst,
  input  logic                      ring_in,
  input  logic                      enable,
  output logic                      busy,
  ring_freq_meter_if.master         meas_if
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [32:0]      THR_EXT   = 33'(DROP_THRESH);

  logic edge_pulse;

  meas_state_e      state_q, state_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_out_q, ovf_out_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic             busy_q, busy_d;

  logic             edge_sat_s;
  logic [CNT_W-1:0] edge_cnt_inc_s;

  ring_edge_sync u_sync (
    .clk        (clk48),
    .rst        (rst),
    .async_in   (ring_in),
    .edge_pulse (edge_pulse)
  );

  // Saturating increment of the edge counter; an edge at all-ones saturates.
  always_comb begin
    edge_sat_s     = edge_pulse & (edge_cnt_q == CNT_MAX);
    edge_cnt_inc_s = edge_cnt_q;
    if (edge_pulse && !edge_sat_s) begin
      edge_cnt_inc_s = edge_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      edge_cnt_inc_s = edge_cnt_q;
    end
  end

  // Gate/hold sequencing, result capture and drop comparison.
  always_comb begin
    state_d     = state_q;
    gate_cnt_d  = gate_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    valid_d     = valid_q;
    ovf_out_d   = ovf_out_q;
    drop_d      = drop_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;

    case (state_q)
      ST_IDLE: begin
        gate_cnt_d = {GW{1'b0}};
        edge_cnt_d = {CNT_W{1'b0}};
        ovf_d      = 1'b0;
        if (enable) begin
          state_d = ST_GATE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GATE: begin
        if (!enable) begin
          // Abort: the partial gate is discarded, no result is presented.
          state_d = ST_IDLE;
        end else if (gate_cnt_q == GATE_LAST) begin
          // An edge in the final gate cycle still belongs to this gate.
          count_d     = edge_cnt_inc_s;
          ovf_out_d   = ovf_q | edge_sat_s;
          valid_d     = 1'b1;
          drop_d      = have_prev_q &&
                        is_drop(33'(prev_q), 33'(edge_cnt_inc_s), THR_EXT);
          prev_d      = edge_cnt_inc_s;
          have_prev_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          gate_cnt_d = gate_cnt_q + {{(GW-1){1'b0}}, 1'b1};
          edge_cnt_d = edge_cnt_inc_s;
          ovf_d      = ovf_q | edge_sat_s;
          state_d    = ST_GATE;
        end
      end

      ST_HOLD: begin
        if (valid_q && meas_if.meas_ready) begin
          valid_d    = 1'b0;
          gate_cnt_d = {GW{1'b0}};
          edge_cnt_d = {CNT_W{1'b0}};
          ovf_d      = 1'b0;
          if (enable) begin
            state_d = ST_GATE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        gate_cnt_d = {GW{1'b0}};
        edge_cnt_d = {CNT_W{1'b0}};
        ovf_d      = 1'b0;
        valid_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and result registers; reset discards any gate in flight.
  always_ff @(posedge clk48) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gate_cnt_q  <= {GW{1'b0}};
      edge_cnt_q  <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      count_q     <= {CNT_W{1'b0}};
      valid_q     <= 1'b0;
      ovf_out_q   <= 1'b0;
      drop_q      <= 1'b0;
      prev_q      <= {CNT_W{1'b0}};
      have_prev_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_cnt_q  <= gate_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      ovf_out_q   <= ovf_out_d;
      drop_q      <= drop_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      busy_q      <= busy_d;
    end
  end

  assign meas_if.meas_count = count_q;
  assign meas_if.meas_valid = valid_q;
  assign meas_if.overflow   = ovf_out_q;
  assign meas_if.drop_flag  = drop_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Scoreboard bench for ring_freq_meter: dut_a (20-bit counter) covers gate
// alignment, drop flag, hold/backpressure, abort and reset; dut_b (4-bit
// counter) covers saturation. Both use a 480-cycle gate.
module tb_ring_freq_meter;
  import ring_meas_pkg::*;

  localparam int G = 480;

  typedef struct {
    logic [19:0] cnt;
    logic        ovf;
    logic        drop;
  } exp_t;

  logic clk;
  logic rst;
  logic en_a, en_b;
  logic busy_a, busy_b;
  logic man_ring, gen_ring;
  logic ring_in;
  int   gen_period;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  ring_freq_meter_if #(.CNT_W(20)) ifa ();
  ring_freq_meter_if #(.CNT_W(4))  ifb ();

  ring_freq_meter #(.GATE_CYCLES(G), .CNT_W(20), .DROP_THRESH(5)) dut_a (
    .clk48 (clk), .rst (rst), .ring_in (ring_in), .enable (en_a),
    .busy (busy_a), .meas_if (ifa)
  );

  ring_freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .DROP_THRESH(5)) dut_b (
    .clk48 (clk), .rst (rst), .ring_in (ring_in), .enable (en_b),
    .busy (busy_b), .meas_if (ifb)
  );

  assign ring_in = (gen_period == 0) ? man_ring : gen_ring;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Square-wave generator; restarts its phase (low half first) on a period change.
  initial begin
    int ph;
    int last;
    ph = 0;
    last = 0;
    gen_ring = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (gen_period == 0) begin
        last = 0;
      end else begin
        if (gen_period != last) begin
          last = gen_period;
          ph = 0;
        end
        gen_ring = (ph >= gen_period / 2);
        ph = (ph + 1) % gen_period;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_res(input string name, input logic [19:0] cnt, input logic ovf,
                           input logic drop, input exp_t e);
    n_checks++;
    if (cnt !== e.cnt || ovf !== e.ovf || drop !== e.drop) begin
      n_fail++;
      $display("FAIL %s: got count=%0d ovf=%0b drop=%0b, required count=%0d ovf=%0b drop=%0b",
               name, cnt, ovf, drop, e.cnt, e.ovf, e.drop);
    end
  endtask

  task automatic push_a(input int c, input logic o, input logic d);
    exp_t e;
    e.cnt = 20'(c); e.ovf = o; e.drop = d;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int c, input logic o, input logic d);
    exp_t e;
    e.cnt = 20'(c); e.ovf = o; e.drop = d;
    q_b.push_back(e);
  endtask

  task automatic wait_valid(input int d, input int limit);
    int n;
    n = 0;
    while (!((d == 0) ? ifa.meas_valid : ifb.meas_valid) && n < limit) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (n >= limit) begin
      n_fail++;
      $display("FAIL wait_valid_%0d: no result within %0d cycles, required meas_valid=1", d, limit);
    end
  endtask

  task automatic accept(input int d);
    if (d == 0) ifa.meas_ready = 1'b1; else ifb.meas_ready = 1'b1;
    tick(1);
    if (d == 0) ifa.meas_ready = 1'b0; else ifb.meas_ready = 1'b0;
  endtask

  // Monitor: pops an expectation when a result appears, re-checks it at acceptance.
  initial begin
    exp_t cur_a, cur_b;
    logic pv_a, pv_b, have_a, have_b;
    pv_a = 1'b0; pv_b = 1'b0; have_a = 1'b0; have_b = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.meas_valid === 1'b1 && !pv_a) begin
        if (q_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL a_unexpected_result: got count=%0d, required no result", ifa.meas_count);
        end else begin
          cur_a = q_a.pop_front();
          have_a = 1'b1;
          check_res("a_result", ifa.meas_count, ifa.overflow, ifa.drop_flag, cur_a);
        end
      end
      if (ifa.meas_valid === 1'b1 && ifa.meas_ready === 1'b1 && have_a) begin
        check_res("a_stable_at_accept", ifa.meas_count, ifa.overflow, ifa.drop_flag, cur_a);
        have_a = 1'b0;
      end
      pv_a = (ifa.meas_valid === 1'b1);

      if (ifb.meas_valid === 1'b1 && !pv_b) begin
        if (q_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected_result: got count=%0d, required no result", ifb.meas_count);
        end else begin
          cur_b = q_b.pop_front();
          have_b = 1'b1;
          check_res("b_result", 20'(ifb.meas_count), ifb.overflow, ifb.drop_flag, cur_b);
        end
      end
      if (ifb.meas_valid === 1'b1 && ifb.meas_ready === 1'b1 && have_b) begin
        check_res("b_stable_at_accept", 20'(ifb.meas_count), ifb.overflow, ifb.drop_flag, cur_b);
        have_b = 1'b0;
      end
      pv_b = (ifb.meas_valid === 1'b1);
    end
  end

  // Watchdog against a hung run.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    ifa.meas_ready = 1'b1; ifb.meas_ready = 1'b1;
    man_ring = 1'b0; gen_period = 0;
    tick(3);
    check("reset_busy_a",  32'(busy_a), 32'd0);
    check("reset_valid_a", 32'(ifa.meas_valid), 32'd0);
    check("reset_count_a", 32'(ifa.meas_count), 32'd0);
    check("reset_ovf_a",   32'(ifa.overflow), 32'd0);
    check("reset_drop_a",  32'(ifa.drop_flag), 32'd0);
    check("reset_busy_b",  32'(busy_b), 32'd0);
    check("reset_valid_b", 32'(ifb.meas_valid), 32'd0);

    // Edge aligned to last gate cycle counts; edge in the HOLD cycle is lost.
    rst = 1'b0;
    push_a(1, 1'b0, 1'b0);
    push_a(0, 1'b0, 1'b0);
    push_a(0, 1'b0, 1'b0);
    en_a = 1'b1;
    tick(1);
    tick(G - 3);
    man_ring = 1'b1;
    tick(2);
    man_ring = 1'b0;
    tick(G);
    man_ring = 1'b1;
    tick(G + 104);
    check("busy_in_gate4", 32'(busy_a), 32'd1);
    en_a = 1'b0;
    tick(2);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_valid", 32'(ifa.meas_valid), 32'd0);

    // Period 48 -> 10 edges; hold result under backpressure for 200 cycles.
    ifa.meas_ready = 1'b0;
    gen_period = 48;
    push_a(10, 1'b0, 1'b0);
    en_a = 1'b1;
    wait_valid(0, 1000);
    tick(200);
    check("hold_valid", 32'(ifa.meas_valid), 32'd1);
    check("hold_count", 32'(ifa.meas_count), 32'd10);
    check("hold_busy",  32'(busy_a), 32'd1);
    push_a(10, 1'b0, 1'b0);
    accept(0);

    // 10 -> 5 sits exactly on the threshold: no drop.
    wait_valid(0, 1000);
    gen_period = 96; tick(20);
    push_a(5, 1'b0, 1'b0);
    accept(0);

    wait_valid(0, 1000);
    gen_period = 16; tick(20);
    push_a(30, 1'b0, 1'b0);
    accept(0);

    // Reset mid-gate: no result, history forgotten.
    wait_valid(0, 1000);
    accept(0);
    tick(100);
    check("busy_before_rst", 32'(busy_a), 32'd1);
    rst = 1'b1; en_a = 1'b0;
    tick(2);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_valid", 32'(ifa.meas_valid), 32'd0);
    rst = 1'b0;
    gen_period = 96; tick(20);
    push_a(5, 1'b0, 1'b0);
    en_a = 1'b1;

    wait_valid(0, 1000);
    gen_period = 16; tick(20);
    push_a(30, 1'b0, 1'b0);
    accept(0);

    // 30 -> 5 is a real drop; 5 -> 6 is not.
    wait_valid(0, 1000);
    gen_period = 96; tick(20);
    push_a(5, 1'b0, 1'b1);
    accept(0);

    wait_valid(0, 1000);
    gen_period = 80; tick(20);
    push_a(6, 1'b0, 1'b0);
    accept(0);

    // enable low during HOLD: accept returns to IDLE.
    wait_valid(0, 1000);
    en_a = 1'b0;
    accept(0);
    tick(2);
    check("stop_busy_a", 32'(busy_a), 32'd0);
    tick(20);
    check("stop_valid_a", 32'(ifa.meas_valid), 32'd0);

    // 4-bit counter: exactly 15 edges is not overflow; 60 edges saturates.
    ifb.meas_ready = 1'b0;
    gen_period = 32; tick(20);
    push_b(15, 1'b0, 1'b0);
    en_b = 1'b1;
    wait_valid(1, 1000);
    gen_period = 8; tick(20);
    push_b(15, 1'b1, 1'b0);
    accept(1);
    wait_valid(1, 1000);
    en_b = 1'b0;
    accept(1);
    tick(2);
    check("stop_busy_b", 32'(busy_b), 32'd0);

    tick(10);
    check("queue_a_empty", 32'(q_a.size()), 32'd0);
    check("queue_b_empty", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
